// File: rtl/divu_seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per DIVU clock,
// result committed to HI/LO only when the control stage signals HiLo-open.
module divu_seq_divider #(
   parameter int          WIDTH     = 32,
   parameter logic [5:0]  DIVU_CODE = 6'b011011,
   parameter logic [5:0]  HILO_OPEN = 6'b111111
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       Signal,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] quo_r;
   logic [WIDTH-1:0] dvs_r;
   logic [CW-1:0]    cnt_r;
   logic             zflag_r;

   logic [WIDTH:0]   t_s;
   logic             ge_s;
   logic [WIDTH-1:0] rem_nxt_s;
   logic [WIDTH-1:0] quo_nxt_s;

   // One restoring step; the compare keeps the shifted-out MSB of rem,
   // and when it succeeds the difference is below dvs so WIDTH bits hold it.
   always_comb begin
      t_s       = {rem_r, quo_r[WIDTH-1]};
      ge_s      = (t_s >= {1'b0, dvs_r});
      quo_nxt_s = {quo_r[WIDTH-2:0], ge_s};
      if (ge_s) begin
         rem_nxt_s = t_s[WIDTH-1:0] - dvs_r;
      end else begin
         rem_nxt_s = t_s[WIDTH-1:0];
      end
   end

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r  <= IDLE;
         rem_r    <= {WIDTH{1'b0}};
         quo_r    <= {WIDTH{1'b0}};
         dvs_r    <= {WIDTH{1'b0}};
         cnt_r    <= {CW{1'b0}};
         zflag_r  <= 1'b0;
         hi       <= {WIDTH{1'b0}};
         lo       <= {WIDTH{1'b0}};
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (Signal == DIVU_CODE) begin
                  rem_r   <= {WIDTH{1'b0}};
                  quo_r   <= dataA;
                  dvs_r   <= dataB;
                  cnt_r   <= {CW{1'b0}};
                  zflag_r <= (dataB == {WIDTH{1'b0}});
                  state_r <= RUN;
                  busy    <= 1'b1;
                  done    <= 1'b0;
               end else begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b0;
               end
            end
            RUN: begin
               if (Signal == DIVU_CODE) begin
                  rem_r <= rem_nxt_s;
                  quo_r <= quo_nxt_s;
                  cnt_r <= cnt_r + CW'(1);
                  if (cnt_r == CW'(WIDTH - 1)) begin
                     state_r <= DONE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     state_r <= RUN;
                  end
               end else begin
                  // Any interruption abandons the divide; HI/LO stay intact.
                  state_r <= IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b0;
               end
            end
            DONE: begin
               if (Signal == HILO_OPEN) begin
                  hi       <= rem_r;
                  lo       <= quo_r;
                  div_zero <= zflag_r;
                  state_r  <= IDLE;
                  done     <= 1'b0;
               end else if (Signal == DIVU_CODE) begin
                  state_r <= DONE;
               end else begin
                  state_r <= IDLE;
                  done    <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divu_seq_divider.sv
// Self-checking bench for divu_seq_divider: vector table, random divides
// against an arithmetic reference, and hand-written multi-cycle corner cases.
module tb_divu_seq_divider;

   localparam logic [5:0] DIVU = 6'b011011;
   localparam logic [5:0] HILO = 6'b111111;
   localparam logic [5:0] ADD  = 6'b100000;

   logic        clk;
   logic        reset;
   logic [5:0]  Signal;
   logic [31:0] dataA;
   logic [31:0] dataB;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        div_zero;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        z;
   } vec_t;

   vec_t vecs[6];

   divu_seq_divider dut (
      .clk(clk), .reset(reset), .Signal(Signal), .dataA(dataA), .dataB(dataB),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // busy and done must never be high together
   always @(negedge clk) begin
      if (!reset) begin
         checks++;
         if (busy && done) begin
            errors++;
            $display("FAIL busy_done_overlap actual=11 required=not-both");
         end
      end
   end

   // Reference: plain unsigned division; divisor 0 gives all-ones and the dividend.
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   task automatic run_iter(input logic [31:0] a, input logic [31:0] b, input bit scramble);
      Signal = DIVU;
      dataA  = a;
      dataB  = b;
      @(posedge clk); #1;
      chk("load_busy", {31'd0, busy}, 32'd1);
      chk("load_done", {31'd0, done}, 32'd0);
      for (int i = 1; i <= 32; i++) begin
         if (scramble) begin
            dataA = $urandom;
            dataB = $urandom;
         end
         @(posedge clk); #1;
         if (i == 31) begin
            chk("edge32_done", {31'd0, done}, 32'd0);
            chk("edge32_busy", {31'd0, busy}, 32'd1);
         end
      end
      chk("edge33_done", {31'd0, done}, 32'd1);
      chk("edge33_busy", {31'd0, busy}, 32'd0);
   endtask

   task automatic commit_check(input logic [31:0] q, input logic [31:0] r, input logic z);
      Signal = HILO;
      @(posedge clk); #1;
      Signal = 6'd0;
      chk("commit_done", {31'd0, done}, 32'd0);
      chk("lo", lo, q);
      chk("hi", hi, r);
      chk("div_zero", {31'd0, div_zero}, {31'd0, z});
   endtask

   initial begin
      logic [31:0] a, b, q, r;

      vecs[0] = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,          z: 1'b0};
      vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0,          z: 1'b0};
      vecs[2] = '{a: 32'd5,          b: 32'd9,          q: 32'd0,          r: 32'd5,          z: 1'b0};
      vecs[3] = '{a: 32'h8000_0000,  b: 32'hFFFF_FFFF,  q: 32'd0,          r: 32'h8000_0000,  z: 1'b0};
      vecs[4] = '{a: 32'd25,         b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd25,         z: 1'b1};
      vecs[5] = '{a: 32'hFFFF_FFFE,  b: 32'hFFFF_FFFF,  q: 32'd0,          r: 32'hFFFF_FFFE,  z: 1'b0};

      reset  = 1'b1;
      Signal = 6'd0;
      dataA  = 32'd0;
      dataB  = 32'd0;
      #2;
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_dz", {31'd0, div_zero}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) begin
         run_iter(vecs[i].a, vecs[i].b, 1'b0);
         commit_check(vecs[i].q, vecs[i].r, vecs[i].z);
      end

      for (int n = 0; n < 24; n++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 7) == 0) b = 32'd0;
         ref_div(a, b, q, r);
         run_iter(a, b, 1'b0);
         commit_check(q, r, (b == 32'd0));
      end

      // DONE holds while DIVU persists, then commits
      run_iter(32'd100, 32'd7, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
         chk("hold_done", {31'd0, done}, 32'd1);
      end
      commit_check(32'd14, 32'd2, 1'b0);

      // DONE with another code discards the result
      run_iter(32'd1000, 32'd3, 1'b0);
      Signal = ADD;
      @(posedge clk); #1;
      chk("discard_done", {31'd0, done}, 32'd0);
      chk("discard_lo", lo, 32'd14);
      chk("discard_hi", hi, 32'd2);

      // Abort mid-RUN at edge 10
      Signal = DIVU;
      dataA  = 32'd50;
      dataB  = 32'd5;
      for (int i = 1; i <= 9; i++) begin
         @(posedge clk); #1;
         chk("abort_run_done", {31'd0, done}, 32'd0);
      end
      Signal = ADD;
      @(posedge clk); #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_hi", hi, 32'd2);
      chk("abort_lo", lo, 32'd14);
      @(posedge clk); #1;
      chk("abort_idle_busy", {31'd0, busy}, 32'd0);

      // Operand changes after load are ignored
      run_iter(32'd1000, 32'd3, 1'b1);
      commit_check(32'd333, 32'd1, 1'b0);

      // Asynchronous reset at iteration 20, then a fresh divide
      Signal = DIVU;
      dataA  = 32'd100;
      dataB  = 32'd7;
      repeat (21) @(posedge clk);
      #1;
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_hi", hi, 32'd0);
      chk("mid_rst_lo", lo, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_iter(32'd9, 32'd2, 1'b0);
      commit_check(32'd4, 32'd1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/divu_seq_divider.md
# divu_seq_divider

Sequential 32-bit unsigned restoring divider, directly downstream of the ALU control stage. It consumes the 6-bit function code that stage drives on its divider output and computes one quotient bit per clock. It commits quotient/remainder into its HI/LO result registers only when the control stage raises the HiLo-open code. HI/LO feed the result mux for MFHI/MFLO.

## Interface
- WIDTH, 32, operand/result width; iteration count equals WIDTH
- DIVU_CODE, 6'b011011, function code that starts/continues a divide
- HILO_OPEN, 6'b111111, function code that commits the result to HI/LO
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- Signal  in  6  function code from ALU control divider output
- dataA  in  WIDTH  dividend; sampled only on load
- dataB  in  WIDTH  divisor; sampled only on load
- hi  out  WIDTH  committed remainder
- lo  out  WIDTH  committed quotient
- busy  out  1  high in RUN
- done  out  1  high in DONE (result ready, not yet committed)
- div_zero  out  1  divisor of committed result was 0

## Operation
- States: IDLE, RUN, DONE. Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, internal regs=0.
- IDLE: Signal==DIVU_CODE at posedge -> load rem=0, quo=dataA, dvs=dataB, cnt=0, zflag=(dataB==0); go RUN. Any other code -> stay IDLE.
- RUN, each posedge with Signal==DIVU_CODE, one restoring step:
  - t = {rem, quo[WIDTH-1]} (WIDTH+1 bits); quo shifts left.
  - If t >= {1'b0,dvs}: rem=t-dvs, quo[0]=1; else rem=t[WIDTH-1:0], quo[0]=0.
  - cnt increments; when cnt reaches WIDTH, go DONE.
- RUN with Signal != DIVU_CODE (including HILO_OPEN) -> abort to IDLE; hi/lo/div_zero unchanged.
- DONE: Signal==HILO_OPEN -> hi=rem, lo=quo, div_zero=zflag, go IDLE. Signal==DIVU_CODE -> hold in DONE. Any other code -> discard result, go IDLE.
- Divisor 0: no special path; the algorithm naturally yields quo=all-ones, rem=dividend. div_zero flags it.
- dataA/dataB changes after load are ignored.
- Subtractor compare must be WIDTH+1 bits wide so that a shifted-out MSB is never lost.

## Timing
- Edge 1 (DIVU seen in IDLE): load. Edges 2..33: 32 iterations. After edge 33, done=1.
- Earliest commit is at edge 34, if HILO_OPEN is present. hi/lo update at that edge; done falls at the same edge.
- This timing matches the control stage: it raises HILO_OPEN after its 33rd DIVU clock.
- busy=1 strictly after edge 1 through edge 33; busy and done are never both high.
- If DIVU reappears in IDLE after a commit, a new divide starts; hi/lo keep the old values until the next commit.
- Reset mid-RUN/DONE: all outputs return to reset values immediately (asynchronous). The first DIVU after reset deassertion starts a fresh load.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- dataA=100, dataB=7, Signal=DIVU for 33 edges then HILO_OPEN -> done=1 after edge 33; at edge 34 lo=14, hi=2, div_zero=0, done=0.
- dataA=0xFFFFFFFF, dataB=1 -> lo=0xFFFFFFFF, hi=0. dataA=5, dataB=9 -> lo=0, hi=5. dataA=0x80000000, dataB=0xFFFFFFFF -> lo=0, hi=0x80000000.
- dataA=25, dataB=0 -> after commit lo=0xFFFFFFFF, hi=25, div_zero=1.
- First commit 100/7. Then start 50/5 and switch Signal to ADD at edge 10 -> busy drops, state IDLE, hi=2 and lo=14 unchanged, done never asserted.
- Change dataA/dataB every cycle during RUN after loading 1000/3 -> lo=333, hi=1.
- Assert reset for half a cycle at iteration 20 -> hi=lo=0, busy=done=0 immediately. A new 9/2 divide then completes with lo=4, hi=1.
